// File: rtl/car_park_sensor.sv
// -----------------------------------------------------------------------------
// car_park_sensor
//
// Front end of the car park occupancy counter. The two raw photo-sensor lines
// at the gate are synchronised, debounced, and fed to a passage-tracking FSM.
// The FSM emits one-cycle pulses that drive the counter's inc/dec inputs
// directly. A car that backs out produces no pulse. An impossible sensor
// pattern produces a fault pulse.
//
// Parameters
//   DB_CYCLES    cycles a synchronised sensor must differ from its filtered
//                value before the filtered value follows it (1..65535)
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      asynchronous, active-high reset
//   i_a          raw outer sensor, 1 = beam blocked (asynchronous)
//   i_b          raw inner sensor, 1 = beam blocked (asynchronous)
//   o_car_enter  one-cycle pulse when an entry sequence completes
//   o_car_exit   one-cycle pulse when an exit sequence completes
//   o_fault      one-cycle pulse on an illegal sensor transition
//   o_busy       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no car in the gate, filtered ab = 00
// E1    | entry: outer beam blocked only (10)
// E2    | entry: both beams blocked (11)
// E3    | entry: inner beam blocked only (01)
// X1    | exit: inner beam blocked only (01)
// X2    | exit: both beams blocked (11)
// X3    | exit: outer beam blocked only (10)
// WAIT  | illegal pattern seen; wait for 00 before trusting the sensors
// -----------------------------------------------------------------------------
module car_park_sensor #(
  parameter int DB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_a,
  input  logic i_b,
  output logic o_car_enter,
  output logic o_car_exit,
  output logic o_fault,
  output logic o_busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    X1   = 3'd4,
    X2   = 3'd5,
    X3   = 3'd6,
    WAIT = 3'd7
  } state_t;

  // Comparing in 17 bits keeps the terminal-count test clean for DB_CYCLES
  // up to 65535 without the 16-bit counter ever having to hold DB_CYCLES.
  localparam logic [16:0] DB_L = 17'(DB_CYCLES);

  // Index 1 carries sensor a, index 0 carries sensor b, so r_filt reads
  // directly as the FSM input pattern {a_f, b_f}.
  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  r_filt;
  logic [15:0] r_cnt [2];
  logic [1:0]  w_hit;

  state_t r_state;
  state_t w_next;
  logic   w_enter;
  logic   w_exit;
  logic   w_fault;
  logic   r_enter;
  logic   r_exit;
  logic   r_fault;
  logic   r_busy;

  // ---------------------------------------------------------------------------
  // Synchroniser and debounce filter
  // ---------------------------------------------------------------------------
  // w_hit flags the cycle on which this difference is the DB_CYCLES-th in a
  // row, so the filtered value flips and the counter clears instead of
  // counting past the threshold.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < 2; i++) begin
      w_hit[i] = (({1'b0, r_cnt[i]} + 17'd1) >= DB_L);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_filt   <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_sync1 <= {i_a, i_b};
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (w_hit[i]) begin
          r_filt[i] <= r_sync2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Passage FSM: next-state and pulse decode
  // ---------------------------------------------------------------------------
  // Any pattern not listed for a state is the pattern that state represents,
  // so the default of holding covers the "unchanged input" case.
  always_comb begin
    w_next  = r_state;
    w_enter = 1'b0;
    w_exit  = 1'b0;
    w_fault = 1'b0;
    case (r_state)
      IDLE: begin
        case (r_filt)
          2'b10:   w_next = E1;
          2'b01:   w_next = X1;
          2'b11:   begin w_next = WAIT; w_fault = 1'b1; end
          default: w_next = IDLE;
        endcase
      end
      E1: begin
        case (r_filt)
          2'b11:   w_next = E2;
          2'b00:   w_next = IDLE;
          2'b01:   begin w_next = WAIT; w_fault = 1'b1; end
          default: w_next = E1;
        endcase
      end
      E2: begin
        case (r_filt)
          2'b01:   w_next = E3;
          2'b10:   w_next = E1;
          2'b00:   begin w_next = IDLE; w_fault = 1'b1; end
          default: w_next = E2;
        endcase
      end
      E3: begin
        case (r_filt)
          2'b00:   begin w_next = IDLE; w_enter = 1'b1; end
          2'b11:   w_next = E2;
          2'b10:   begin w_next = WAIT; w_fault = 1'b1; end
          default: w_next = E3;
        endcase
      end
      X1: begin
        case (r_filt)
          2'b11:   w_next = X2;
          2'b00:   w_next = IDLE;
          2'b10:   begin w_next = WAIT; w_fault = 1'b1; end
          default: w_next = X1;
        endcase
      end
      X2: begin
        case (r_filt)
          2'b10:   w_next = X3;
          2'b01:   w_next = X1;
          2'b00:   begin w_next = IDLE; w_fault = 1'b1; end
          default: w_next = X2;
        endcase
      end
      X3: begin
        case (r_filt)
          2'b00:   begin w_next = IDLE; w_exit = 1'b1; end
          2'b11:   w_next = X2;
          2'b01:   begin w_next = WAIT; w_fault = 1'b1; end
          default: w_next = X3;
        endcase
      end
      WAIT: begin
        if (r_filt == 2'b00) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Passage FSM: state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_enter <= 1'b0;
      r_exit  <= 1'b0;
      r_fault <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_enter <= w_enter;
      r_exit  <= w_exit;
      r_fault <= w_fault;
      r_busy  <= (w_next != IDLE);
    end
  end

  assign o_car_enter = r_enter;
  assign o_car_exit  = r_exit;
  assign o_fault     = r_fault;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_car_park_sensor.sv
// -----------------------------------------------------------------------------
// tb_car_park_sensor
//
// Directed table of sensor patterns with expected pulse counts, hand-written
// latency / glitch / reset sequences, and a randomized phase. A behavioural
// reference model runs alongside the DUT the whole time and is compared every
// cycle.
// -----------------------------------------------------------------------------
module tb_car_park_sensor;

  localparam int DB = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a   = 1'b0;
  logic b   = 1'b0;
  logic car_enter, car_exit, fault, busy;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  car_park_sensor #(.DB_CYCLES(DB)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_a         (a),
    .i_b         (b),
    .o_car_enter (car_enter),
    .o_car_exit  (car_exit),
    .o_fault     (fault),
    .o_busy      (busy)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // A passage is a walk along a pattern list (00,10,11,01,00 for entry, the
  // bit-swapped list for exit). Stepping forward advances, stepping back
  // retreats, anything else is a fault. The filter is modelled as "the last
  // DB synchronised samples all disagree with the filtered value".
  // ---------------------------------------------------------------------------
  logic [1:0] m_sync1 = '0;
  logic [1:0] m_s     = '0;
  logic       m_fa = 1'b0, m_fb = 1'b0;
  bit         hist_a[$];
  bit         hist_b[$];
  int         m_dir  = 0;   // 0 idle, 1 entry, 2 exit, 3 waiting for 00
  int         m_step = 0;
  logic       m_enter = 1'b0, m_exit = 1'b0, m_fault = 1'b0, m_busy = 1'b0;

  function automatic logic [1:0] pat(int dir, int idx);
    logic [1:0] e [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] r;
    r = e[idx];
    return (dir == 2) ? {r[0], r[1]} : r;
  endfunction

  function automatic bit all_diff(bit q[$], logic f);
    foreach (q[i]) if (q[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sync1 = '0; m_s = '0; m_fa = 1'b0; m_fb = 1'b0;
      hist_a.delete(); hist_b.delete();
      m_dir = 0; m_step = 0;
      m_enter = 1'b0; m_exit = 1'b0; m_fault = 1'b0; m_busy = 1'b0;
    end else begin
      logic [1:0] f;
      f = {m_fa, m_fb};
      m_enter = 1'b0; m_exit = 1'b0; m_fault = 1'b0;
      if (m_dir == 0) begin
        if (f == 2'b10)      begin m_dir = 1; m_step = 1; end
        else if (f == 2'b01) begin m_dir = 2; m_step = 1; end
        else if (f == 2'b11) begin m_dir = 3; m_fault = 1'b1; end
      end else if (m_dir == 3) begin
        if (f == 2'b00) m_dir = 0;
      end else if (f != pat(m_dir, m_step)) begin
        if (f == pat(m_dir, m_step + 1)) begin
          if (m_step == 3) begin
            if (m_dir == 1) m_enter = 1'b1; else m_exit = 1'b1;
            m_dir = 0;
          end else begin
            m_step++;
          end
        end else if (f == pat(m_dir, m_step - 1)) begin
          if (m_step == 1) m_dir = 0; else m_step--;
        end else begin
          m_fault = 1'b1;
          m_dir = (f == 2'b00) ? 0 : 3;
        end
      end
      m_busy = (m_dir != 0);
      hist_a.push_back(m_s[1]);
      hist_b.push_back(m_s[0]);
      if (hist_a.size() > DB) void'(hist_a.pop_front());
      if (hist_b.size() > DB) void'(hist_b.pop_front());
      if (hist_a.size() == DB && all_diff(hist_a, m_fa)) m_fa = m_s[1];
      if (hist_b.size() == DB && all_diff(hist_b, m_fb)) m_fb = m_s[0];
      m_s = m_sync1;
      m_sync1 = {a, b};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if ({car_enter, car_exit, fault, busy} !== {m_enter, m_exit, m_fault, m_busy}) begin
        n_err++;
        $display("FAIL model t=%0t enter/exit/fault/busy dut=%b%b%b%b model=%b%b%b%b",
                 $time, car_enter, car_exit, fault, busy, m_enter, m_exit, m_fault, m_busy);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  int c_en, c_ex, c_fl, c_busy_hi;

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    c_en = 0; c_ex = 0; c_fl = 0; c_busy_hi = 0;
  endtask

  task automatic hold(logic [1:0] ab, int n);
    {a, b} = ab;
    repeat (n) begin
      @(posedge clk); #1;
      c_en      += int'(car_enter);
      c_ex      += int'(car_exit);
      c_fl      += int'(fault);
      c_busy_hi += int'(busy);
    end
  endtask

  // Index of the first sampled cycle where the chosen output is high, or -1
  // if it never rises within the limit.
  task automatic first_high(int which, int limit, output int idx);
    idx = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (idx < 0 && ((which == 0) ? busy : car_enter)) idx = i;
    end
  endtask

  typedef struct {
    logic [1:0] ab;
    int         cyc;
    int         en;
    int         ex;
    int         fl;
    int         busy_end;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int idx;

    tbl.push_back('{2'b00, 20, 0, 0, 0, 0});
    // full entry
    tbl.push_back('{2'b10, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b11, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b01, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b00, 10, 1, 0, 0, 0});
    // full exit
    tbl.push_back('{2'b01, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b11, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b10, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b00, 10, 0, 1, 0, 0});
    // backed out
    tbl.push_back('{2'b10, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b11, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b10, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b00, 10, 0, 0, 0, 0});
    // 11 from idle, then recovery and a clean entry
    tbl.push_back('{2'b11, 10, 0, 0, 1, 1});
    tbl.push_back('{2'b00, 10, 0, 0, 0, 0});
    tbl.push_back('{2'b10, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b11, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b01, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b00, 10, 1, 0, 0, 0});
    // E1 double transition to 01
    tbl.push_back('{2'b10, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b01, 10, 0, 0, 1, 1});
    tbl.push_back('{2'b00, 10, 0, 0, 0, 0});
    // E2 straight to 00
    tbl.push_back('{2'b10, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b11, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b00, 10, 0, 0, 1, 0});
    // X3 double transition to 01
    tbl.push_back('{2'b01, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b11, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b10, 10, 0, 0, 0, 1});
    tbl.push_back('{2'b01, 10, 0, 0, 1, 1});
    tbl.push_back('{2'b00, 10, 0, 0, 0, 0});

    // reset state
    #2 rst = 1'b1;
    #1;
    check("reset enter", int'(car_enter), 0);
    check("reset exit",  int'(car_exit),  0);
    check("reset fault", int'(fault),     0);
    check("reset busy",  int'(busy),      0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // directed table
    for (int i = 0; i < tbl.size(); i++) begin
      clr_counts();
      hold(tbl[i].ab, tbl[i].cyc);
      check($sformatf("row%0d enter", i), c_en, tbl[i].en);
      check($sformatf("row%0d exit", i),  c_ex, tbl[i].ex);
      check($sformatf("row%0d fault", i), c_fl, tbl[i].fl);
      check($sformatf("row%0d busy", i),  int'(busy), tbl[i].busy_end);
    end

    // latency: busy rises DB+2 cycles after the raw change, enter likewise
    {a, b} = 2'b10;
    first_high(0, 10, idx);
    check("busy latency", idx, DB + 2);
    clr_counts();
    hold(2'b11, 10);
    hold(2'b01, 10);
    {a, b} = 2'b00;
    first_high(1, 10, idx);
    check("enter latency", idx, DB + 2);

    // 1-cycle glitches on a never reach the FSM
    clr_counts();
    for (int k = 0; k < 5; k++) begin
      hold(2'b10, 1);
      hold(2'b00, 6);
    end
    check("glitch1 busy", c_busy_hi, 0);
    check("glitch1 pulses", c_en + c_ex + c_fl, 0);

    // 3-cycle pulse on a: E1 then back to IDLE, no pulse
    clr_counts();
    hold(2'b10, 3);
    hold(2'b00, 10);
    check("glitch3 busy seen", int'(c_busy_hi > 0), 1);
    check("glitch3 pulses", c_en + c_ex + c_fl, 0);
    check("glitch3 busy end", int'(busy), 0);

    // reset while in E3 discards the passage
    hold(2'b10, 10);
    hold(2'b11, 10);
    hold(2'b01, 10);
    check("pre-reset busy", int'(busy), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset busy", int'(busy), 0);
    check("midreset pulses", int'(car_enter) + int'(car_exit) + int'(fault), 0);
    {a, b} = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clr_counts();
    hold(2'b00, 20);
    check("post-reset enter", c_en, 0);
    check("post-reset busy", c_busy_hi, 0);

    // reset release with both beams blocked: fault from IDLE
    @(negedge clk);
    rst = 1'b1;
    {a, b} = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    clr_counts();
    hold(2'b11, 10);
    check("blocked-release fault", c_fl, 1);
    check("blocked-release busy", int'(busy), 1);
    hold(2'b00, 10);

    // randomized phase, checked every cycle against the model
    for (int k = 0; k < 400; k++) begin
      hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 8)));
    end
    hold(2'b00, 10);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
